// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the sequential ALU.
//   OP_*  : 3-bit operation codes presented on Op (101..111 all act as NOP).
//   ST_*  : controller state encoding, also exported on the debug state port.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_SBB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_NOP = 3'b101;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/nbit_adder.sv
// nbit_adder: N-bit adder with carry-in.
//   a, b     : operands
//   cin      : carry into bit 0
//   sum      : N-bit sum
//   cout     : carry out of bit N-1
//   c_msb_in : carry into bit N-1 (used for signed overflow detection)
module nbit_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         c_msb_in
);

  logic [N:0] full;

  assign full     = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  assign sum      = full[N-1:0];
  assign cout     = full[N];
  // The MSB sum bit is a ^ b ^ carry-in, so the carry-in is recovered by XOR.
  assign c_msb_in = full[N-1] ^ a[N-1] ^ b[N-1];

endmodule

// File: rtl/seq_alu.sv
// seq_alu: N-bit sequential ALU (ADD/SUB/ADC/SBB in one cycle, unsigned
// shift-add MUL in N cycles) with registered result and flags.
//   Clock, Reset_n            : clock, asynchronous active-low reset
//   Start, Op                 : request and operation code
//   First_Input, Second_Input : operands A and B
//   Busy, Done                : MUL in progress / one-cycle completion pulse
//   Result, Result_Hi         : result (low product half) / high product half
//   Carry, Overflow, Zero, Negative : registered condition flags
//   dbg_state_o               : controller state (ST_IDLE / ST_MUL)
// Handshake: Start is sampled on a rising edge only while idle (Busy low);
// a Start seen while Busy is dropped. Done is high for exactly one cycle
// after the edge that registers the result, and never together with Busy.
module seq_alu
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic [2:0]   Op,
  input  logic [N-1:0] First_Input,
  input  logic [N-1:0] Second_Input,
  output logic         Busy,
  output logic         Done,
  output logic [N-1:0] Result,
  output logic [N-1:0] Result_Hi,
  output logic         Carry,
  output logic         Overflow,
  output logic         Zero,
  output logic         Negative,
  output logic [0:0]   dbg_state_o
);

  localparam int            CW   = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [0:0]    state_q,  state_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [N-1:0]  mcand_q,  mcand_d;
  logic [N-1:0]  acc_hi_q, acc_hi_d;
  logic [N-1:0]  acc_lo_q, acc_lo_d;   // holds the multiplier, shifted out LSB first
  logic          done_q,   done_d;
  logic [N-1:0]  res_q,    res_d;
  logic [N-1:0]  hi_q,     hi_d;
  logic          carry_q,  carry_d;
  logic          ovf_q,    ovf_d;
  logic          zero_q,   zero_d;
  logic          neg_q,    neg_d;

  logic [N-1:0]  add_a, add_b, add_sum;
  logic          add_cin, add_cout, add_cmsb;
  logic [N-1:0]  mul_hi_next, mul_lo_next;

  // One adder serves both the single-cycle ops (idle) and the MUL
  // accumulate step; the controller state selects its inputs.
  always_comb begin
    add_a   = First_Input;
    add_b   = Second_Input;
    add_cin = 1'b0;
    if (state_q == ST_MUL) begin
      add_a = acc_hi_q;
      add_b = acc_lo_q[0] ? mcand_q : '0;
    end else begin
      case (Op)
        OP_SUB: begin
          add_b   = ~Second_Input;
          add_cin = 1'b1;
        end
        OP_ADC: add_cin = carry_q;
        OP_SBB: begin
          add_b   = ~Second_Input;
          add_cin = carry_q;
        end
        default: ;
      endcase
    end
  end

  nbit_adder #(.N(N)) u_adder (
    .a        (add_a),
    .b        (add_b),
    .cin      (add_cin),
    .sum      (add_sum),
    .cout     (add_cout),
    .c_msb_in (add_cmsb)
  );

  // {carry, acc_hi, acc_lo} >> 1 after the conditional accumulate.
  assign mul_hi_next = {add_cout, add_sum[N-1:1]};
  assign mul_lo_next = {add_sum[0], acc_lo_q[N-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    done_d   = 1'b0;
    res_d    = res_q;
    hi_d     = hi_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          case (Op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBB: begin
              res_d   = add_sum;
              hi_d    = '0;
              carry_d = add_cout;
              ovf_d   = add_cout ^ add_cmsb;
              zero_d  = (add_sum == '0);
              neg_d   = add_sum[N-1];
              done_d  = 1'b1;
            end
            OP_MUL: begin
              mcand_d  = First_Input;
              acc_lo_d = Second_Input;
              acc_hi_d = '0;
              cnt_d    = '0;
              state_d  = ST_MUL;
            end
            default: done_d = 1'b1;   // NOP: outputs hold
          endcase
        end
      end
      ST_MUL: begin
        acc_hi_d = mul_hi_next;
        acc_lo_d = mul_lo_next;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          res_d   = mul_lo_next;
          hi_d    = mul_hi_next;
          carry_d = |mul_hi_next;
          ovf_d   = |mul_hi_next;
          zero_d  = ~|{mul_hi_next, mul_lo_next};
          neg_d   = mul_hi_next[N-1];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      done_q   <= 1'b0;
      res_q    <= '0;
      hi_q     <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      done_q   <= done_d;
      res_q    <= res_d;
      hi_q     <= hi_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  assign Busy        = (state_q == ST_MUL);
  assign Done        = done_q;
  assign Result      = res_q;
  assign Result_Hi   = hi_q;
  assign Carry       = carry_q;
  assign Overflow    = ovf_q;
  assign Zero        = zero_q;
  assign Negative    = neg_q;
  assign dbg_state_o = state_q;

endmodule
